// File: rtl/serial_subtractor_pkg.sv
// Shared types and the arithmetic reference for the bit-serial subtractor.
// The reference function is used by the embedded checks (SERIAL_SUBTRACTOR_ASSERT_EN).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned REF_MAX_W = 64;

  // Returns {borrow, diff} in bits [w:0]; operands are masked down to w bits.
  function automatic logic [REF_MAX_W:0] ref_sub(
    input int unsigned          w,
    input logic [REF_MAX_W-1:0] a,
    input logic [REF_MAX_W-1:0] b
  );
    logic [REF_MAX_W-1:0] mask;
    logic [REF_MAX_W:0]   full;
    logic [REF_MAX_W:0]   res;
    if (w >= REF_MAX_W) begin
      mask = '1;
    end else begin
      mask = (64'd1 << w) - 64'd1;
    end
    full = {1'b0, a & mask} - {1'b0, b & mask};
    res  = {1'b0, full[REF_MAX_W-1:0] & mask} | ({64'd0, full[REF_MAX_W]} << w);
    return res;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_ASSERT_EN to compile in the embedded concurrent assertions.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               w_d;
  logic               w_bout;
  logic               w_last;

  full_subtractor u_cell (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state logic; DONE never overlaps with a new accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand shift registers, result register, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign diff       = r_res;
  assign borrow_out = r_borrow;

`ifdef SERIAL_SUBTRACTOR_ASSERT_EN
  logic [WIDTH-1:0]     r_chk_a;
  logic [WIDTH-1:0]     r_chk_b;
  logic [CNT_W-1:0]     r_chk_busy;
  logic [REF_MAX_W:0]   w_chk_ref;

  // Shadow copy of the accepted operands and a count of BUSY cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_a    <= '0;
      r_chk_b    <= '0;
      r_chk_busy <= '0;
    end else if (in_valid && in_ready) begin
      r_chk_a    <= a;
      r_chk_b    <= b;
      r_chk_busy <= '0;
    end else if (r_state == BUSY) begin
      r_chk_busy <= r_chk_busy + CNT_W'(1);
    end else begin
      r_chk_busy <= r_chk_busy;
    end
  end

  // Reference result for the operands currently in flight.
  always_comb begin
    w_chk_ref = ref_sub(WIDTH, REF_MAX_W'(r_chk_a), REF_MAX_W'(r_chk_b));
  end

  a_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid))
    else $error("serial_subtractor: in_ready and out_valid both high at %0t", $time);

  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(diff) && $stable(borrow_out)))
    else $error("serial_subtractor: result changed while stalled at %0t", $time);

  a_busy_max: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == BUSY) |-> (r_chk_busy < CNT_W'(WIDTH)))
    else $error("serial_subtractor: BUSY overran at %0t", $time);

  a_busy_len: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == DONE && $past(r_state) == BUSY) |-> (r_chk_busy == CNT_W'(WIDTH)))
    else $error("serial_subtractor: BUSY length wrong at %0t", $time);

  a_result: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(out_valid) |-> ({borrow_out, diff} == w_chk_ref[WIDTH:0]))
    else $error("serial_subtractor: wrong result at %0t", $time);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against a plain-arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int N_RAND = 1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  // {borrow, diff} as a (WIDTH+1)-bit unsigned subtraction.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = {1'b0, x} - {1'b0, y};
    return r;
  endfunction

  // Presents operands and holds in_valid through one rising edge; returns at the following negedge.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    for (int g = 0; g < 40 && !in_ready; g++) @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'hA5};
    logic [WIDTH-1:0] vb [4] = '{8'h03, 8'h05, 8'hFF, 8'hA5};
    logic [WIDTH-1:0] ed [4] = '{8'h02, 8'hFE, 8'h01, 8'h00};
    logic             eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      wait_valid(lat);
      checks++; if (lat != WIDTH) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, WIDTH); end
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL dir%0d_diff got %h want %h", i, diff, ed[i]); end
      checks++; if (borrow_out !== eb[i]) begin errors++; $display("FAIL dir%0d_borrow got %b want %b", i, borrow_out, eb[i]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_ready_in_done got %b want 0", i, in_ready); end
      retire();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_retire got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] x, y;
    logic [WIDTH:0]   exp;
    int lat;
    x = WIDTH'($urandom); y = WIDTH'($urandom);
    exp = model(x, y);
    start_op(x, y);
    wait_valid(lat);
    checks++; if (lat != WIDTH) begin errors++; $display("FAIL hold_latency got %0d want %0d", lat, WIDTH); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {borrow_out, diff} !== exp) begin
        errors++; $display("FAIL hold_cycle%0d got valid=%b res=%h want 1/%h", c, out_valid, {borrow_out, diff}, exp);
      end
    end
    retire();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_retire got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int spurious;
    start_op(8'h5A, 8'h3C);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != WIDTH - 4) begin errors++; $display("FAIL busy_latency got %0d want %0d", lat, WIDTH - 4); end
    checks++; if ({borrow_out, diff} !== 9'h01E) begin
      errors++; $display("FAIL busy_result got %h want 01e", {borrow_out, diff});
    end
    retire();
    spurious = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL busy_second_result got %0d valid cycles want 0", spurious); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int spurious;
    start_op(8'hC3, 8'h1E);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    checks++; if (diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_data got diff=%h borrow=%b want 00/0", diff, borrow_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_no_result got %0d valid cycles want 0", spurious); end
    start_op(8'h10, 8'h01);
    wait_valid(lat);
    checks++; if (lat != WIDTH) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", lat, WIDTH); end
    checks++; if ({borrow_out, diff} !== 9'h00F) begin
      errors++; $display("FAIL rstmid_result got %h want 00f", {borrow_out, diff});
    end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] q[$];
    logic [WIDTH:0] exp;
    int sent, got, both_high;
    bit prev_retire, accepted;
    sent = 0; got = 0; both_high = 0; prev_retire = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); in_valid = 1'b1;
    for (int cyc = 0; cyc < 60000 && got < N_RAND; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready && out_valid) both_high++;
      if (prev_retire) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_retire op %0d got %b want 1", got, in_ready); end
      end
      prev_retire = out_valid && out_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious result %h with nothing pending", {borrow_out, diff});
        end else begin
          exp = q.pop_front();
          if ({borrow_out, diff} !== exp) begin
            errors++; $display("FAIL b2b_result op %0d got %h want %h", got, {borrow_out, diff}, exp);
          end
        end
        got++;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        q.push_back(model(a, b));
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      if (accepted) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      in_valid = (sent < N_RAND);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (got != N_RAND) begin errors++; $display("FAIL b2b_count got %0d want %0d", got, N_RAND); end
    checks++; if (both_high != 0) begin errors++; $display("FAIL b2b_ready_valid_overlap got %0d want 0", both_high); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
